// File: rtl/fir_pkg.sv
// fir_pkg: shared state type, tap-index sizing and saturation modes for the FIR MAC family
package fir_pkg;
    typedef enum logic [1:0] {LOAD, IDLE, MAC, OUT} fir_state_e;
    localparam int SAT_OFF = 0;
    localparam int SAT_ON = 1;
    function automatic int tap_w(input int taps);
        return (taps < 2) ? 1 : $clog2(taps);
    endfunction
endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up arithmetic right shift of the accumulator with optional saturation
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int DATA_W = 16,
    parameter int OUT_SHIFT = 15,
    parameter int SAT_EN = SAT_ON
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] y,
    output logic              sat
);
    localparam logic [ACC_W:0] BIAS = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shf;
    logic [ACC_W-DATA_W+1:0] hi;
    logic ovf;
    // one guard bit keeps the rounding bias from overflowing a full-scale accumulator
    assign sum = {acc[ACC_W-1], acc} + BIAS;
    assign shf = sum >>> OUT_SHIFT;
    assign hi = shf[ACC_W:DATA_W-1];
    assign ovf = (SAT_EN != 0) && !(&hi || !(|hi));
    assign sat = ovf;
    assign y = !ovf ? shf[DATA_W-1:0] :
               shf[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed FIR, one multiplier walks all taps per accepted sample
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS = 64,
    parameter int ACC_W = 40,
    parameter int OUT_SHIFT = 15,
    parameter int SAT_EN = SAT_ON
) (
    input  logic              clk,
    input  logic              fir_restn,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              coef_valid,
    input  logic              coef_reload,
    output logic              coef_loaded,
    input  logic [DATA_W-1:0] x_in,
    input  logic              x_valid,
    output logic              x_ready,
    output logic [DATA_W-1:0] y_out,
    output logic              y_valid,
    output logic              y_sat
);
    localparam int TW = tap_w(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [TW-1:0] LAST = TW'(TAPS - 1);
    fir_state_e state;
    logic [TW-1:0] idx, k, head, rd;
    logic signed [COEF_W-1:0] b [TAPS];
    logic signed [DATA_W-1:0] dl [TAPS];
    logic signed [PW-1:0] prod;
    logic [ACC_W-1:0] acc;
    logic [DATA_W-1:0] r;
    logic r_sat;
    // modular result is exact because the true read index is always below TAPS
    assign rd = (head >= k) ? head - k : head - k + TW'(TAPS);
    assign prod = b[k] * dl[rd];
    fir_round_sat #(
        .ACC_W(ACC_W),
        .DATA_W(DATA_W),
        .OUT_SHIFT(OUT_SHIFT),
        .SAT_EN(SAT_EN)
    ) u_round_sat (
        .acc(acc),
        .y(r),
        .sat(r_sat)
    );
    always_ff @(posedge clk)
        if (fir_restn && state == LOAD && coef_valid && !coef_reload) b[idx] <= coef_in;
    always_ff @(posedge clk or negedge fir_restn) begin
        if (!fir_restn) begin
            state <= LOAD;
            idx <= '0;
            k <= '0;
            head <= '0;
            acc <= '0;
            coef_loaded <= 1'b0;
            x_ready <= 1'b0;
            y_out <= '0;
            y_valid <= 1'b0;
            y_sat <= 1'b0;
            for (int i = 0; i < TAPS; i++) dl[i] <= '0;
        end else if (coef_reload) begin
            state <= LOAD;
            idx <= '0;
            k <= '0;
            head <= '0;
            acc <= '0;
            coef_loaded <= 1'b0;
            x_ready <= 1'b0;
            y_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) dl[i] <= '0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                LOAD: if (coef_valid) begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        coef_loaded <= 1'b1;
                        x_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                IDLE: if (x_valid) begin
                    dl[head] <= x_in;
                    acc <= '0;
                    k <= '0;
                    x_ready <= 1'b0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
                    k <= (k == LAST) ? '0 : k + 1'b1;
                    if (k == LAST) state <= OUT;
                end
                default: begin
                    y_out <= r;
                    y_sat <= r_sat;
                    y_valid <= 1'b1;
                    head <= (head == LAST) ? '0 : head + 1'b1;
                    x_ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: scoreboard bench, convolution reference model against saturating and wrapping instances
module tb_fir_mac_engine;
    localparam int TAPS = 64;
    localparam int SH = 15;
    logic clk = 1'b0;
    logic fir_restn = 1'b0;
    logic coef_valid = 1'b0;
    logic coef_reload = 1'b0;
    logic x_valid = 1'b0;
    logic [15:0] coef_in = '0;
    logic [15:0] x_in = '0;
    logic coef_loaded, x_ready, y_valid, y_sat;
    logic [15:0] y_out;
    logic coef_loaded_w, x_ready_w, y_valid_w, y_sat_w;
    logic [15:0] y_out_w;
    always #5 clk = ~clk;
    fir_mac_engine dut (
        .clk(clk), .fir_restn(fir_restn), .coef_in(coef_in), .coef_valid(coef_valid),
        .coef_reload(coef_reload), .coef_loaded(coef_loaded), .x_in(x_in), .x_valid(x_valid),
        .x_ready(x_ready), .y_out(y_out), .y_valid(y_valid), .y_sat(y_sat)
    );
    fir_mac_engine #(.SAT_EN(0)) dut_w (
        .clk(clk), .fir_restn(fir_restn), .coef_in(coef_in), .coef_valid(coef_valid),
        .coef_reload(coef_reload), .coef_loaded(coef_loaded_w), .x_in(x_in), .x_valid(x_valid),
        .x_ready(x_ready_w), .y_out(y_out_w), .y_valid(y_valid_w), .y_sat(y_sat_w)
    );
    typedef struct {
        logic [15:0] y;
        logic        s;
        logic [15:0] yw;
        int          c;
    } exp_t;
    exp_t exp_q[$];
    exp_t last_e;
    shortint hist[$];
    shortint mb[TAPS];
    int nb = 0;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int last_acc = -1;
    bit hold_chk = 1'b0;
    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // y[n] = sum b[k]*x[n-k] over the samples seen since the last clear, then round and clamp
    function automatic exp_t predict(input int c);
        exp_t e;
        longint acc = 0;
        longint r;
        for (int k = 0; k < hist.size() && k < TAPS; k++) acc += longint'(mb[k]) * longint'(hist[k]);
        r = (acc + (longint'(1) << (SH - 1))) >>> SH;
        e.yw = r[15:0];
        e.s = (r > 32767) || (r < -32768);
        e.y = (r > 32767) ? 16'h7FFF : (r < -32768) ? 16'h8000 : r[15:0];
        e.c = c;
        return e;
    endfunction
    always @(posedge clk) begin
        cyc++;
        if (!fir_restn || coef_reload) begin
            hist.delete();
            exp_q.delete();
            nb = 0;
            last_acc = -1;
        end else begin
            if (coef_valid && nb < TAPS) begin
                mb[nb] = shortint'(coef_in);
                nb++;
            end
            if (x_valid && x_ready) begin
                hist.push_front(shortint'(x_in));
                if (hist.size() > TAPS) void'(hist.pop_back());
                exp_q.push_back(predict(cyc));
                if (hold_chk && last_acc >= 0) chk("accept_spacing", cyc - last_acc, TAPS + 2);
                last_acc = cyc;
            end
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (y_valid || y_valid_w) begin
            chk("y_valid_pair", y_valid_w, y_valid);
            chk("y_valid_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_e = e;
                chk("y_out", y_out, e.y);
                chk("y_sat", y_sat, e.s);
                chk("y_out_wrap", y_out_w, e.yw);
                chk("y_sat_wrap", y_sat_w, 0);
                chk("latency", cyc - e.c, TAPS + 1);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic load(input int mode);
        for (int k = 0; k < TAPS; k++) begin
            @(negedge clk);
            coef_valid = 1'b1;
            coef_in = (mode == 0) ? 16'(2 * (k + 1)) : (mode == 1) ? ((k == 0) ? 16'h0001 : 16'h0000) :
                      (mode == 2) ? 16'h7FFF : 16'($urandom);
        end
        @(negedge clk);
        coef_valid = 1'b0;
        chk("coef_loaded_after_load", coef_loaded, 1);
        chk("x_ready_after_load", x_ready, 1);
        chk("wrap_inst_loaded", coef_loaded_w, 1);
        chk("wrap_inst_ready", x_ready_w, 1);
    endtask
    task automatic send(input logic [15:0] v, input bit keep);
        int i = 0;
        x_in = v;
        x_valid = 1'b1;
        while (!x_ready && i < 4 * TAPS) begin
            @(negedge clk);
            i++;
        end
        chk("send_x_ready", x_ready, 1);
        @(posedge clk);
        #1;
        if (!keep) x_valid = 1'b0;
    endtask
    task automatic reload();
        @(negedge clk);
        coef_reload = 1'b1;
        @(negedge clk);
        coef_reload = 1'b0;
        chk("coef_loaded_after_reload", coef_loaded, 0);
        chk("x_ready_after_reload", x_ready, 0);
    endtask
    task automatic wait_drain();
        for (int i = 0; i < 4 * TAPS && exp_q.size() > 0; i++) tick(1);
        chk("drain_pending", exp_q.size(), 0);
    endtask
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        last_e.y = '0;
        last_e.s = 1'b0;
        tick(3);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_coef_loaded", coef_loaded, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_sat", y_sat, 0);
        fir_restn = 1'b1;
        tick(2);
        chk("x_ready_in_load", x_ready, 0);
        load(0);
        send(16'h4000, 0);
        repeat (TAPS) send(16'h0000, 0);
        wait_drain();
        reload();
        load(1);
        send(16'h4000, 0);
        send(16'h3FFF, 0);
        @(negedge clk);
        coef_valid = 1'b1;
        coef_in = 16'h7FFF;
        @(negedge clk);
        coef_valid = 1'b0;
        send(16'h4000, 0);
        wait_drain();
        reload();
        load(2);
        repeat (TAPS) send(16'h7FFF, 0);
        repeat (TAPS) send(16'h8000, 0);
        wait_drain();
        reload();
        load(3);
        last_acc = -1;
        hold_chk = 1'b1;
        repeat (40) send(16'($urandom), 1);
        x_valid = 1'b0;
        wait_drain();
        hold_chk = 1'b0;
        send(16'($urandom), 0);
        tick(10);
        chk("x_ready_in_mac", x_ready, 0);
        coef_reload = 1'b1;
        coef_valid = 1'b1;
        coef_in = 16'h7FFF;
        @(negedge clk);
        coef_reload = 1'b0;
        coef_valid = 1'b0;
        chk("abort_coef_loaded", coef_loaded, 0);
        chk("abort_x_ready", x_ready, 0);
        chk("abort_y_out_held", y_out, last_e.y);
        chk("abort_y_sat_held", y_sat, last_e.s);
        tick(2 * TAPS);
        chk("abort_still_loading", x_ready, 0);
        load(0);
        send(16'h4000, 0);
        repeat (4) send(16'h0000, 0);
        wait_drain();
        send(16'h4000, 0);
        tick(20);
        #2;
        fir_restn = 1'b0;
        #1;
        chk("async_rst_y_out", y_out, 0);
        chk("async_rst_y_valid", y_valid, 0);
        chk("async_rst_y_sat", y_sat, 0);
        chk("async_rst_x_ready", x_ready, 0);
        chk("async_rst_coef_loaded", coef_loaded, 0);
        tick(3);
        fir_restn = 1'b1;
        tick(2);
        load(3);
        repeat (10) send(16'($urandom), 0);
        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
